// File: rtl/mem_lsu.sv
// Load/store unit in front of a word-wide data memory.
// Byte/half/word loads and stores with big-endian lanes; sub-word stores are
// done as a read-modify-write. Every dm_* output comes from a register or the
// state, so address and write data hold still for the whole write cycle.
//
// state | meaning
// IDLE  | ready for a request; the response of the previous request may be out
// LOAD  | memory read; lane extracted and extended into rsp_rdata at the edge
// MERGE | memory read; store lane merged into the write-data register
// WRITE | memory write of the write-data register; ack at the edge
// ERR   | misaligned or reserved size; error response at the edge, no access
module mem_lsu #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] dm_address,
    output logic              dm_mem_read,
    output logic              dm_mem_write,
    output logic [DATA_W-1:0] dm_write_data,
    input  logic [DATA_W-1:0] dm_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MERGE,
        S_WRITE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [15:0]         sdata_q, sdata_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic                req_bad;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [4:0]          lane_sh;
    logic [DATA_W-1:0]   load_ext;
    logic [DATA_W-1:0]   merged;

    // Address bits above the word index wrap and are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    // Reserved size, or an address not aligned to the access size.
    always_comb begin
        req_bad = (req_size == 2'b11)
               || ((req_size == 2'b01) && req_addr[0])
               || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    end

    // Big-endian lane extraction/extension for loads and lane merge for stores.
    always_comb begin
        lane_sh = {~off_q, 3'b000};
        case (off_q)
            2'd0:    rd_byte = dm_read_data[31:24];
            2'd1:    rd_byte = dm_read_data[23:16];
            2'd2:    rd_byte = dm_read_data[15:8];
            default: rd_byte = dm_read_data[7:0];
        endcase
        rd_half = off_q[1] ? dm_read_data[15:0] : dm_read_data[31:16];
        case (size_q)
            2'b00:   load_ext = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
            2'b01:   load_ext = {{16{rd_half[15] & ~uns_q}}, rd_half};
            default: load_ext = dm_read_data;
        endcase
        if (size_q == 2'b00) begin
            merged = (dm_read_data & ~(32'h0000_00FF << lane_sh))
                   | ({24'h0, sdata_q[7:0]} << lane_sh);
        end else if (off_q[1]) begin
            merged = {dm_read_data[31:16], sdata_q};
        end else begin
            merged = {sdata_q, dm_read_data[15:0]};
        end
    end

    // Next-state, request capture and response generation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        sdata_d     = sdata_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr[ADDR_W+1:2];
                    off_d   = req_addr[1:0];
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    sdata_d = req_wdata[15:0];
                    if (req_bad) begin
                        state_d = S_ERR;
                    end else if (!req_write) begin
                        state_d = S_LOAD;
                    end else if (req_size == 2'b10) begin
                        wdata_d = req_wdata;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_MERGE;
                    end
                end
            end
            S_LOAD: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_ext;
                state_d     = S_IDLE;
            end
            S_MERGE: begin
                wdata_d = merged;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                state_d     = S_IDLE;
            end
            S_ERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_rdata_d = '0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            sdata_q     <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            sdata_q     <= sdata_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready     = (state_q == S_IDLE);
    assign dm_mem_read   = (state_q == S_LOAD) || (state_q == S_MERGE);
    assign dm_mem_write  = (state_q == S_WRITE);
    assign dm_address    = addr_q;
    assign dm_write_data = wdata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_rdata     = rsp_rdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: a word-array data memory, a transaction-level reference
// model checked every cycle, and directed requests with literal expectations.
module tb_mem_lsu;

    localparam int ADDR_W = 9;

    logic              clk;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] dm_address;
    logic              dm_mem_read;
    logic              dm_mem_write;
    logic [31:0]       dm_write_data;
    logic [31:0]       dm_read_data;

    logic [31:0] env_mem [512];
    logic [31:0] ref_mem [512];

    int n_pass;
    int n_total;

    // Monitor/model state.
    int          cyc;
    logic        pend;
    int          p_due;
    logic [8:0]  p_idx;
    logic [31:0] p_rdata;
    logic        p_err;
    logic [31:0] p_word;
    int          p_nrd;
    int          p_nwr;
    int          nrd;
    int          nwr;
    logic [31:0] wr_d;
    logic [31:0] last_rdata;
    int          mon_acc;
    int          mon_rsp;
    int          mon_drop;

    mem_lsu #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .dm_address   (dm_address),
        .dm_mem_read  (dm_mem_read),
        .dm_mem_write (dm_mem_write),
        .dm_write_data(dm_write_data),
        .dm_read_data (dm_read_data)
    );

    assign dm_read_data = env_mem[dm_address];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Big-endian byte k of a word is bits [31-8k -: 8].
    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic u, input logic [1:0] off);
        int o;
        logic [7:0] b;
        logic [15:0] h;
        o = int'(off);
        b = w[31-8*o -: 8];
        if (sz == 2'b00) begin
            if (!u && b[7]) return 32'hFFFF_FF00 | {24'h0, b};
            return {24'h0, b};
        end
        if (sz == 2'b01) begin
            h = {w[31-8*o -: 8], w[23-8*o -: 8]};
            if (!u && h[15]) return 32'hFFFF_0000 | {16'h0, h};
            return {16'h0, h};
        end
        return w;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] off, input logic [31:0] d);
        int o;
        logic [31:0] r;
        o = int'(off);
        r = w;
        if (sz == 2'b00) begin
            r[31-8*o -: 8] = d[7:0];
        end else if (sz == 2'b01) begin
            r[31-8*o -: 8] = d[15:8];
            r[23-8*o -: 8] = d[7:0];
        end else begin
            r = d;
        end
        return r;
    endfunction

    task automatic set_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] d);
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
    endtask

    // One request; waits for acceptance and response with bounded loops.
    task automatic do_req(input string nm, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d, input int lat_exp,
                          output logic [31:0] rdata, output logic err);
        logic acc;
        logic got;
        int   lat;
        acc   = 1'b0;
        got   = 1'b0;
        lat   = 0;
        rdata = '0;
        err   = 1'b0;
        @(posedge clk); #1;
        set_req(w, sz, u, a, d);
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({nm, "_accept"}, {31'h0, acc}, 32'd1);
        if (acc) begin
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    got   = 1'b1;
                    lat   = k;
                    rdata = rsp_rdata;
                    err   = rsp_err;
                    break;
                end
            end
            chk({nm, "_rsp_seen"}, {31'h0, got}, 32'd1);
            chk({nm, "_latency"}, lat, lat_exp);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          n;
        int          a0;
        int          r0;
        logic        ow [8];
        logic [31:0] oa [8];
        logic [31:0] od [8];

        n_pass = 0;
        n_total = 0;
        cyc = 0;
        pend = 1'b0;
        p_due = 0;
        p_idx = '0;
        p_rdata = '0;
        p_err = 1'b0;
        p_word = '0;
        p_nrd = 0;
        p_nwr = 0;
        nrd = 0;
        nwr = 0;
        wr_d = '0;
        last_rdata = '0;
        mon_acc = 0;
        mon_rsp = 0;
        mon_drop = 0;
        for (int i = 0; i < 512; i++) begin
            env_mem[i] = '0;
            ref_mem[i] = '0;
        end
        env_mem[4] = 32'h80F0_7F01;
        ref_mem[4] = 32'h80F0_7F01;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        set_req(1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

        fork
            forever begin
                @(posedge clk);
                if (dm_mem_write) env_mem[dm_address] <= dm_write_data;
            end
            forever begin
                @(negedge clk);
                if (!reset_n) begin
                    chk("rst_ready", {31'h0, req_ready}, 32'd1);
                    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
                    chk("rst_dm_rw", {30'h0, dm_mem_read, dm_mem_write}, 32'd0);
                    chk("rst_rdata", rsp_rdata, 32'd0);
                    if (pend) mon_drop++;
                    pend = 1'b0;
                    last_rdata = '0;
                    nrd = 0;
                    nwr = 0;
                end else begin
                    logic exp_v;
                    exp_v = pend && (p_due == cyc);
                    chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_v});
                    chk("req_ready", {31'h0, req_ready}, {31'h0, (!pend || exp_v)});
                    chk("dm_excl", {31'h0, dm_mem_read & dm_mem_write}, 32'd0);
                    if (rsp_valid) mon_rsp++;
                    if (dm_mem_read || dm_mem_write) begin
                        chk("dm_access_busy", {31'h0, pend && !exp_v}, 32'd1);
                        if (pend) chk("dm_address", {23'h0, dm_address}, {23'h0, p_idx});
                        if (dm_mem_read) nrd++;
                        if (dm_mem_write) begin
                            nwr++;
                            wr_d = dm_write_data;
                        end
                    end
                    if (exp_v) begin
                        chk("rsp_rdata", rsp_rdata, p_rdata);
                        chk("rsp_err", {31'h0, rsp_err}, {31'h0, p_err});
                        chk("read_cycles", nrd, p_nrd);
                        chk("write_cycles", nwr, p_nwr);
                        if (p_nwr != 0) begin
                            chk("write_data", wr_d, p_word);
                            ref_mem[p_idx] = p_word;
                        end
                        last_rdata = p_rdata;
                        pend = 1'b0;
                    end else begin
                        chk("rsp_err_idle", {31'h0, rsp_err}, 32'd0);
                        chk("rdata_hold", rsp_rdata, last_rdata);
                    end
                    if (req_valid && req_ready) begin
                        mon_acc++;
                        pend    = 1'b1;
                        nrd     = 0;
                        nwr     = 0;
                        p_idx   = req_addr[ADDR_W+1:2];
                        p_rdata = '0;
                        p_err   = 1'b0;
                        p_word  = '0;
                        p_due   = cyc + 2;
                        p_nrd   = 0;
                        p_nwr   = 0;
                        if ((req_size == 2'b11) || (req_size == 2'b01 && req_addr[0])
                            || (req_size == 2'b10 && req_addr[1:0] != 2'b00)) begin
                            p_err = 1'b1;
                        end else if (!req_write) begin
                            p_rdata = m_load(ref_mem[p_idx], req_size, req_unsigned, req_addr[1:0]);
                            p_nrd   = 1;
                        end else if (req_size == 2'b10) begin
                            p_word = req_wdata;
                            p_nwr  = 1;
                        end else begin
                            p_word = m_store(ref_mem[p_idx], req_size, req_addr[1:0], req_wdata);
                            p_nrd  = 1;
                            p_nwr  = 1;
                            p_due  = cyc + 3;
                        end
                    end
                end
                cyc++;
            end
        join_none

        #2;
        chk("init_ready", {31'h0, req_ready}, 32'd1);
        chk("init_rsp", {30'h0, rsp_valid, rsp_err}, 32'd0);
        chk("init_rdata", rsp_rdata, 32'd0);
        chk("init_dm", {21'h0, dm_address, dm_mem_read, dm_mem_write}, 32'd0);
        chk("init_wdata", dm_write_data, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Loads from the preloaded word.
        do_req("lb",  1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 2, rd, er); chk("lb_val",  rd, 32'hFFFF_FF80);
        do_req("lbu", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, 2, rd, er); chk("lbu_val", rd, 32'h0000_0080);
        do_req("lh",  1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 2, rd, er); chk("lh_val",  rd, 32'hFFFF_80F0);
        do_req("lhu", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 2, rd, er); chk("lhu_val", rd, 32'h0000_80F0);
        do_req("lh2", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, rd, er); chk("lh2_val", rd, 32'h0000_7F01);
        do_req("lw",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, rd, er); chk("lw_val",  rd, 32'h80F0_7F01);
        do_req("lb3", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, rd, er); chk("lb3_val", rd, 32'h0000_0001);

        // Sub-word stores merge into the word.
        do_req("sb", 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 3, rd, er); chk("sb_ack", rd, 32'h0);
        do_req("sh", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_BEEF, 3, rd, er); chk("sh_ack", rd, 32'h0);
        do_req("lw_m", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, rd, er); chk("merged_word", rd, 32'h80AB_BEEF);

        // Word store.
        do_req("sw", 1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, 2, rd, er);
        chk("sw_ack", rd, 32'h0);
        chk("sw_mem", env_mem[8], 32'hDEAD_BEEF);

        // Errors.
        do_req("e_lh", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, 2, rd, er);
        chk("e_lh_err", {31'h0, er}, 32'd1); chk("e_lh_rd", rd, 32'h0);
        do_req("e_lw", 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 2, rd, er);
        chk("e_lw_err", {31'h0, er}, 32'd1);
        do_req("e_sz", 1'b1, 2'b11, 1'b0, 32'h0, 32'hFFFF_FFFF, 2, rd, er);
        chk("e_sz_err", {31'h0, er}, 32'd1); chk("e_sz_rd", rd, 32'h0);
        chk("e_mem0", env_mem[0], 32'h0);
        do_req("lw_a", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, rd, er); chk("after_err_w4", rd, 32'h80AB_BEEF);
        chk("after_err_w8", env_mem[8], 32'hDEAD_BEEF);

        // Continuous req_valid, alternating sw/lw.
        for (int i = 0; i < 8; i++) begin
            ow[i] = (i % 2 == 0);
            oa[i] = 32'h40 + 32'(i / 2) * 4;
            od[i] = 32'h1234_0000 + 32'(i);
        end
        a0 = mon_acc;
        r0 = mon_rsp;
        n = 0;
        @(posedge clk); #1;
        set_req(ow[0], 2'b10, 1'b0, oa[0], od[0]);
        req_valid = 1'b1;
        for (int c = 0; c < 200 && n < 8; c++) begin
            @(negedge clk);
            if (req_ready) n++;
            @(posedge clk); #1;
            if (n < 8) set_req(ow[n], 2'b10, 1'b0, oa[n], od[n]);
        end
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("stream_issued", n, 8);
        chk("stream_acc", mon_acc - a0, 8);
        chk("stream_rsp", mon_rsp - r0, 8);
        chk("stream_mem17", env_mem[17], 32'h1234_0002);
        chk("stream_mem19", env_mem[19], 32'h1234_0006);
        chk("stream_last_rd", rsp_rdata, 32'h1234_0006);

        // Reset in the MERGE cycle of a byte store.
        @(posedge clk); #1;
        set_req(1'b1, 2'b00, 1'b0, 32'h10, 32'h0000_0055);
        req_valid = 1'b1;
        @(negedge clk);
        chk("rst_pre_ready", {31'h0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("merge_read", {30'h0, dm_mem_read, dm_mem_write}, 32'd2);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_async_dm", {30'h0, dm_mem_read, dm_mem_write}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("rst_w4_kept", env_mem[4], 32'h80AB_BEEF);
        chk("rst_dropped", mon_drop, 1);
        do_req("lw_r", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, rd, er); chk("rst_lw", rd, 32'h80AB_BEEF);

        repeat (3) @(posedge clk);
        chk("acc_vs_rsp", mon_acc, mon_rsp + mon_drop);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d/%0d checks passed, required completion", n_pass, n_total);
        $fatal(1);
    end

endmodule
